// File: rtl/msu_fill.sv
// msu_fill: copies bursts of bytes from a byte-fetch source into the MSU
// data buffer and then runs the matching status-register write handshake.
//
// Requests (rising edges of status_in[4]/[5]/[0], any change of status_in[6])
// are latched as pending. They are serviced one at a time in the order
// data > refill > ctrl > audio.
//
// Ports
//   clkin, reset            clock, async active-high reset
//   status_in[6:0]          MSU status word (request sources)
//   addr_in[31:0]           data seek address, sampled on data_start rise
//   src_req/src_addr        byte-fetch request (level) and address
//   src_data/src_valid      fetched byte and its one-cycle completion strobe
//   pgm_address/pgm_data    buffer write address / data
//   pgm_we                  buffer write strobe, active low, one cycle per byte
//   msu_address_ext(_write) read-pointer preset value / strobe
//   status_reset_bits/status_set_bits/status_reset_we  status write port
module msu_fill #(
    parameter int HALF_LEN  = 8192,
    parameter int STAT_HOLD = 2
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [6:0]  status_in,
    input  logic [31:0] addr_in,
    output logic        src_req,
    output logic [31:0] src_addr,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic [13:0] pgm_address,
    output logic [7:0]  pgm_data,
    output logic        pgm_we,
    output logic [13:0] msu_address_ext,
    output logic        msu_address_ext_write,
    output logic [5:0]  status_reset_bits,
    output logic [5:0]  status_set_bits,
    output logic        status_reset_we
);

    localparam logic [13:0] LEN         = 14'(HALF_LEN);
    localparam logic [15:0] HOLD        = 16'(STAT_HOLD);
    localparam logic [15:0] HOLD_LAST   = 16'(STAT_HOLD - 1);
    localparam logic [15:0] PRESET_LAST = 16'(2 * STAT_HOLD - 1);

    typedef enum logic [2:0] {IDLE, PRESET, FETCH, WRITE, STAT_HI, STAT_LO} state_t;

    state_t      state, state_nx;
    logic [6:0]  prev_stat;
    logic        data_pend, refill_pend, ctrl_pend, audio_pend;
    logic [31:0] addr_pend;
    logic [31:0] fp;
    logic [13:0] wp;
    logic [13:0] count;
    logic [7:0]  byte_q;
    logic [13:0] ext_q;
    logic [5:0]  rst_bits, set_bits;
    logic [15:0] hold_cnt;
    logic        in_refill;   // current burst is a refill (zero status masks)
    logic        data_done;   // a data burst has completed; refills now legal

    logic data_rise, audio_rise, ctrl_rise, refill_chg;
    logic do_data, do_refill, do_ctrl, do_audio, do_cap, do_write, do_done;
    logic unused_bits;

    assign data_rise   = status_in[4] & ~prev_stat[4];
    assign audio_rise  = status_in[5] & ~prev_stat[5];
    assign ctrl_rise   = status_in[0] & ~prev_stat[0];
    assign refill_chg  = status_in[6] ^ prev_stat[6];
    assign unused_bits = ^prev_stat[3:1];

    // Next state and one-cycle action flags for the datapath.
    always_comb begin
        state_nx  = state;
        do_data   = 1'b0;
        do_refill = 1'b0;
        do_ctrl   = 1'b0;
        do_audio  = 1'b0;
        do_cap    = 1'b0;
        do_write  = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend) begin
                    do_data  = 1'b1;
                    state_nx = PRESET;
                end else if (refill_pend && data_done) begin
                    do_refill = 1'b1;
                    state_nx  = FETCH;
                end else if (ctrl_pend) begin
                    do_ctrl  = 1'b1;
                    state_nx = STAT_HI;
                end else if (audio_pend) begin
                    do_audio = 1'b1;
                    state_nx = STAT_HI;
                end
            end
            PRESET: begin
                if (hold_cnt == PRESET_LAST) begin
                    // FETCH entry point: a newer data request restarts here
                    if (data_pend) begin
                        do_data  = 1'b1;
                        state_nx = PRESET;
                    end else begin
                        state_nx = FETCH;
                    end
                end
            end
            FETCH: begin
                if (src_valid) begin
                    do_cap   = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                do_write = 1'b1;
                if (count == 14'd1) begin
                    do_done  = 1'b1;
                    state_nx = STAT_HI;
                end else if (data_pend) begin
                    do_data  = 1'b1;
                    state_nx = PRESET;
                end else begin
                    state_nx = FETCH;
                end
            end
            STAT_HI: if (hold_cnt == HOLD_LAST) state_nx = STAT_LO;
            STAT_LO: if (hold_cnt == HOLD_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            prev_stat   <= 7'd0;
            data_pend   <= 1'b0;
            refill_pend <= 1'b0;
            ctrl_pend   <= 1'b0;
            audio_pend  <= 1'b0;
            addr_pend   <= 32'd0;
            fp          <= 32'd0;
            wp          <= 14'd0;
            count       <= 14'd0;
            byte_q      <= 8'd0;
            ext_q       <= 14'd0;
            rst_bits    <= 6'd0;
            set_bits    <= 6'd0;
            hold_cnt    <= 16'd0;
            in_refill   <= 1'b0;
            data_done   <= 1'b0;
        end else begin
            prev_stat <= status_in;
            // A new edge wins over the clear of the request being serviced.
            data_pend   <= data_rise | (data_pend & ~do_data);
            refill_pend <= (refill_chg & data_done) | (refill_pend & ~do_refill & ~do_data);
            ctrl_pend   <= ctrl_rise | (ctrl_pend & ~do_ctrl);
            audio_pend  <= audio_rise | (audio_pend & ~do_audio);
            if (data_rise) addr_pend <= addr_in;

            // do_data restarts the hold phase even when PRESET re-enters itself.
            hold_cnt <= (state_nx != state || do_data) ? 16'd0 : hold_cnt + 16'd1;

            if (do_cap) byte_q <= src_data;
            if (do_write) begin
                fp    <= fp + 32'd1;
                wp    <= wp + 14'd1;
                count <= count - 14'd1;
            end
            // Placed after do_write so an abort-restart overrides the advance.
            if (do_data) begin
                fp        <= addr_pend;
                wp        <= addr_pend[13:0];
                ext_q     <= addr_pend[13:0];
                count     <= LEN;
                in_refill <= 1'b0;
            end
            if (do_refill) begin
                wp        <= {~status_in[6], 13'h0};
                count     <= LEN;
                in_refill <= 1'b1;
            end
            if (do_done) begin
                rst_bits <= in_refill ? 6'b000000 : 6'b010000;
                set_bits <= 6'b000000;
                if (!in_refill) data_done <= 1'b1;
            end
            if (do_ctrl) begin
                rst_bits <= {3'b000, ~status_in[2:1], 1'b1};
                set_bits <= {3'b000, status_in[2:1], 1'b0};
            end
            if (do_audio) begin
                rst_bits <= 6'b100000;
                set_bits <= 6'b000000;
            end
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    assign src_req               = (state == FETCH);
    assign src_addr              = fp;
    assign pgm_address           = wp;
    assign pgm_data              = byte_q;
    assign pgm_we                = ~(state == WRITE);
    assign msu_address_ext       = ext_q;
    assign msu_address_ext_write = (state == PRESET) && (hold_cnt < HOLD);
    assign status_reset_bits     = rst_bits;
    assign status_set_bits       = set_bits;
    assign status_reset_we       = (state == STAT_HI);

endmodule

// File: tb/tb_msu_fill.sv
// Directed bench for msu_fill (HALF_LEN=4, STAT_HOLD=2). Stimulus pushes the
// expected fetches, buffer writes, pointer presets and status writes into
// queues; negedge monitors pop and compare as the DUT produces them.
module tb_msu_fill;

    localparam int HL = 4;
    localparam int SH = 2;

    logic        clkin, reset;
    logic [6:0]  status_in;
    logic [31:0] addr_in;
    logic        src_req;
    logic [31:0] src_addr;
    logic [7:0]  src_data;
    logic        src_valid;
    logic [13:0] pgm_address;
    logic [7:0]  pgm_data;
    logic        pgm_we;
    logic [13:0] msu_address_ext;
    logic        msu_address_ext_write;
    logic [5:0]  status_reset_bits, status_set_bits;
    logic        status_reset_we;

    msu_fill #(.HALF_LEN(HL), .STAT_HOLD(SH)) dut (
        .clkin(clkin), .reset(reset), .status_in(status_in), .addr_in(addr_in),
        .src_req(src_req), .src_addr(src_addr), .src_data(src_data), .src_valid(src_valid),
        .pgm_address(pgm_address), .pgm_data(pgm_data), .pgm_we(pgm_we),
        .msu_address_ext(msu_address_ext), .msu_address_ext_write(msu_address_ext_write),
        .status_reset_bits(status_reset_bits), .status_set_bits(status_set_bits),
        .status_reset_we(status_reset_we)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic src_en;

    logic [31:0] q_fetch[$];
    logic [21:0] q_wr[$];   // {addr14, data8}
    logic [11:0] q_st[$];   // {reset6, set6}
    logic [13:0] q_ext[$];

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fdat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [31:0] fa, input logic [13:0] wa, input int n);
        for (int i = 0; i < n; i++) begin
            logic [13:0] w;
            logic [31:0] f;
            w = wa + 14'(i);
            f = fa + 32'(i);
            q_fetch.push_back(f);
            q_wr.push_back({w, fdat(f)});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    function automatic int pending();
        return q_fetch.size() + q_wr.size() + q_st.size() + q_ext.size();
    endfunction

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (pending() != 0 && t < 400) begin
            @(negedge clkin);
            t++;
        end
        chk({tag, "_drain"}, pending(), 0);
        cyc(6);
    endtask

    // Byte source: answers each request 3 cycles after it rises.
    initial begin
        int wcnt;
        logic [31:0] e;
        wcnt = 0;
        forever begin
            @(negedge clkin);
            if (src_valid) begin
                src_valid = 1'b0;
                wcnt = 0;
            end else if (src_req && src_en) begin
                if (wcnt == 2) begin
                    chk("fetch_expected", q_fetch.size() != 0, 1);
                    if (q_fetch.size() != 0) begin
                        e = q_fetch.pop_front();
                        chk("fetch_addr", src_addr, e);
                    end
                    src_data  = fdat(src_addr);
                    src_valid = 1'b1;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Output monitors: buffer writes, status writes, pointer presets.
    initial begin
        logic st_prev, ext_prev;
        int st_w, ext_w;
        logic [11:0] cur_st;
        logic [21:0] ew;
        logic [13:0] ee;
        st_prev = 0; ext_prev = 0; st_w = 0; ext_w = 0; cur_st = 0;
        forever begin
            @(negedge clkin);
            if (!pgm_we) begin
                chk("wr_expected", q_wr.size() != 0, 1);
                if (q_wr.size() != 0) begin
                    ew = q_wr.pop_front();
                    chk("wr_addr", pgm_address, ew[21:8]);
                    chk("wr_data", pgm_data, ew[7:0]);
                end
            end
            if (status_reset_we && !st_prev) begin
                chk("st_expected", q_st.size() != 0, 1);
                if (q_st.size() != 0) begin
                    cur_st = q_st.pop_front();
                    chk("st_reset_bits", status_reset_bits, cur_st[11:6]);
                    chk("st_set_bits", status_set_bits, cur_st[5:0]);
                end
                st_w = 1;
            end else if (status_reset_we) begin
                st_w++;
            end else if (st_prev) begin
                chk("st_width", st_w, SH);
                chk("st_reset_hold", status_reset_bits, cur_st[11:6]);
                chk("st_set_hold", status_set_bits, cur_st[5:0]);
            end
            if (msu_address_ext_write && !ext_prev) begin
                chk("ext_expected", q_ext.size() != 0, 1);
                if (q_ext.size() != 0) begin
                    ee = q_ext.pop_front();
                    chk("ext_addr", msu_address_ext, ee);
                end
                ext_w = 1;
            end else if (msu_address_ext_write) begin
                ext_w++;
            end else if (ext_prev) begin
                chk("ext_width", ext_w, SH);
            end
            st_prev  = status_reset_we;
            ext_prev = msu_address_ext_write;
        end
    end

    initial begin
        int t;
        reset = 1'b1; status_in = 7'd0; addr_in = 32'd0;
        src_valid = 1'b0; src_data = 8'd0; src_en = 1'b1;
        cyc(3);
        chk("rst_src_req", src_req, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_pgm_we", pgm_we, 1);
        chk("rst_pgm_address", pgm_address, 0);
        chk("rst_pgm_data", pgm_data, 0);
        chk("rst_ext", msu_address_ext, 0);
        chk("rst_ext_write", msu_address_ext_write, 0);
        chk("rst_reset_bits", status_reset_bits, 0);
        chk("rst_set_bits", status_set_bits, 0);
        chk("rst_status_we", status_reset_we, 0);
        reset = 1'b0;
        cyc(2);

        // Data burst crossing the 0x2FFF/0x3000 boundary
        addr_in = 32'h0001_2FFE;
        q_ext.push_back(14'h2FFE);
        push_burst(32'h0001_2FFE, 14'h2FFE, HL);
        q_st.push_back({6'h10, 6'h00});
        status_in[4] = 1'b1;
        drain("data1");

        // Refills: fetch continues, write pointer from ~status_in[6]
        push_burst(32'h0001_3002, 14'h0000, HL);
        q_st.push_back(12'h000);
        status_in[6] = 1'b1;
        drain("refill1");
        push_burst(32'h0001_3006, 14'h2000, HL);
        q_st.push_back(12'h000);
        status_in[6] = 1'b0;
        drain("refill0");

        // Ctrl status write, audio_ctrl = 01
        status_in[2:1] = 2'b01;
        cyc(1);
        q_st.push_back({6'h05, 6'h02});
        status_in[0] = 1'b1;
        drain("ctrl");

        // Data and audio in the same cycle: data first
        status_in[4] = 1'b0;
        cyc(2);
        addr_in = 32'h0000_0200;
        q_ext.push_back(14'h0200);
        push_burst(32'h0000_0200, 14'h0200, HL);
        q_st.push_back({6'h10, 6'h00});
        q_st.push_back({6'h20, 6'h00});
        status_in[4] = 1'b1;
        status_in[5] = 1'b1;
        drain("data_audio");

        // Abort: new data_start lands before the 2nd write finishes
        status_in[4] = 1'b0;
        cyc(2);
        addr_in = 32'h0000_0050;
        q_ext.push_back(14'h0050);
        push_burst(32'h0000_0050, 14'h0050, 2);
        q_ext.push_back(14'h0100);
        push_burst(32'h0000_0100, 14'h0100, HL);
        q_st.push_back({6'h10, 6'h00});
        status_in[4] = 1'b1;
        cyc(2);
        status_in[4] = 1'b0;
        t = 0;
        while (pgm_we !== 1'b0 && t < 100) begin
            @(negedge clkin);
            t++;
        end
        chk("abort_first_write", pgm_we, 0);
        addr_in = 32'h0000_0100;
        status_in[4] = 1'b1;
        drain("abort");

        // Reset during FETCH
        status_in[4] = 1'b0;
        cyc(2);
        src_en = 1'b0;
        addr_in = 32'h0000_0300;
        q_ext.push_back(14'h0300);
        status_in[4] = 1'b1;
        t = 0;
        while (src_req !== 1'b1 && t < 50) begin
            @(negedge clkin);
            t++;
        end
        chk("fetch_reached", src_req, 1);
        reset = 1'b1;
        status_in = 7'd0;
        #1;
        chk("midrst_src_req", src_req, 0);
        chk("midrst_pgm_we", pgm_we, 1);
        chk("midrst_status_we", status_reset_we, 0);
        cyc(2);
        reset = 1'b0;
        src_en = 1'b1;
        cyc(30);
        chk("final_queues", pending(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
